// File: rtl/msrv32_pkg.sv
// Shared msrv32 definitions: AHB transfer/size codes, load/store size codes and the
// data-side master FSM states.
package msrv32_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransNonseq = 2'b10
  } htrans_e;

  localparam logic [2:0] HsizeByte = 3'b000;
  localparam logic [2:0] HsizeHalf = 3'b001;
  localparam logic [2:0] HsizeWord = 3'b010;

  localparam logic [1:0] SizeByte    = 2'b00;
  localparam logic [1:0] SizeHalf    = 2'b01;
  localparam logic [1:0] SizeWord    = 2'b10;
  localparam logic [1:0] SizeIllegal = 2'b11;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAddr  = 3'd1,
    StData  = 3'd2,
    StErr   = 3'd3,
    StDrain = 3'd4,
    StResp  = 3'd5
  } dmem_state_e;

  // The illegal size code is reported as a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SizeByte: mis = 1'b0;
      SizeHalf: mis = addr_lo[0];
      SizeWord: mis = (addr_lo != 2'b00);
      default:  mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/msrv32_wait_timer.sv
// Saturating count of consecutive HREADY-low cycles; flags the cycle on which the count
// reaches TIMEOUT_CYCLES. A TIMEOUT_CYCLES of 0 disables the flag.
module msrv32_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic hready_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || hready_i) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign expired_o = (TIMEOUT_CYCLES != 0) && en_i && !hready_i && (cnt_d == CntMax);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/msrv32_dmem_ahb_master.sv
// Data-side AHB-Lite master for msrv32: one outstanding load/store, wait states, two-cycle
// ERROR response, HREADY timeout and misalignment rejection. All bus/response outputs are registered.
module msrv32_dmem_ahb_master
  import msrv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic [31:0] req_addr_in,
  input  logic        req_write_in,
  input  logic [1:0]  req_size_in,
  input  logic [31:0] req_wdata_in,
  output logic        rsp_valid_out,
  output logic [31:0] rsp_rdata_out,
  output logic        rsp_err_out,
  output logic        rsp_misaligned_out,
  output logic [1:0]  rsp_addr_1_to_0_out,
  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  output logic [31:0] hwdata_out,
  input  logic [31:0] hrdata_in,
  input  logic        hready_in,
  input  logic        hresp_in
);

  dmem_state_e state_q;
  logic [31:0] wdata_q;
  logic        timer_en;
  logic        timeout;

  assign req_ready_out = (state_q == StIdle);
  assign timer_en      = (state_q == StAddr) || (state_q == StData);

  msrv32_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i    (ms_riscv32_mp_clk_in),
    .rst_ni   (ms_riscv32_mp_rst_in),
    .en_i     (timer_en),
    .hready_i (hready_in),
    .expired_o(timeout)
  );

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q             <= StIdle;
      wdata_q             <= '0;
      rsp_valid_out       <= 1'b0;
      rsp_rdata_out       <= '0;
      rsp_err_out         <= 1'b0;
      rsp_misaligned_out  <= 1'b0;
      rsp_addr_1_to_0_out <= '0;
      haddr_out           <= '0;
      htrans_out          <= HtransIdle;
      hwrite_out          <= 1'b0;
      hsize_out           <= '0;
      hwdata_out          <= '0;
    end else begin
      rsp_valid_out      <= 1'b0;
      rsp_err_out        <= 1'b0;
      rsp_misaligned_out <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_in) begin
            if (is_misaligned(req_size_in, req_addr_in[1:0])) begin
              rsp_valid_out       <= 1'b1;
              rsp_err_out         <= 1'b1;
              rsp_misaligned_out  <= 1'b1;
              rsp_addr_1_to_0_out <= req_addr_in[1:0];
              state_q             <= StResp;
            end else begin
              haddr_out  <= req_addr_in;
              hwrite_out <= req_write_in;
              hsize_out  <= {1'b0, req_size_in};
              htrans_out <= HtransNonseq;
              wdata_q    <= req_wdata_in;
              state_q    <= StAddr;
            end
          end
        end
        StAddr: begin
          // htrans stays NONSEQ into DRAIN so the slave still sees a stable address phase.
          if (timeout) begin
            rsp_valid_out       <= 1'b1;
            rsp_err_out         <= 1'b1;
            rsp_addr_1_to_0_out <= haddr_out[1:0];
            state_q             <= StDrain;
          end else if (hready_in) begin
            htrans_out <= HtransIdle;
            hwdata_out <= wdata_q;
            state_q    <= StData;
          end
        end
        StData: begin
          if (timeout) begin
            rsp_valid_out       <= 1'b1;
            rsp_err_out         <= 1'b1;
            rsp_addr_1_to_0_out <= haddr_out[1:0];
            state_q             <= StDrain;
          end else if (hresp_in) begin
            if (hready_in) begin
              rsp_valid_out       <= 1'b1;
              rsp_err_out         <= 1'b1;
              rsp_addr_1_to_0_out <= haddr_out[1:0];
              state_q             <= StIdle;
            end else begin
              state_q <= StErr;
            end
          end else if (hready_in) begin
            rsp_valid_out       <= 1'b1;
            rsp_addr_1_to_0_out <= haddr_out[1:0];
            if (!hwrite_out) begin
              rsp_rdata_out <= hrdata_in;
            end
            state_q <= StIdle;
          end
        end
        StErr: begin
          if (hready_in) begin
            rsp_valid_out       <= 1'b1;
            rsp_err_out         <= 1'b1;
            rsp_addr_1_to_0_out <= haddr_out[1:0];
            state_q             <= StIdle;
          end
        end
        StDrain: begin
          if (hready_in) begin
            htrans_out <= HtransIdle;
            state_q    <= StIdle;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_dmem_ahb_master.sv
// Directed bench for msrv32_dmem_ahb_master: loads, stores, wait states, misalignment,
// slave ERROR, timeout (TIMEOUT_CYCLES = 4) and reset mid-transfer.
module tb_msrv32_dmem_ahb_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_mis;
  logic [1:0]  rsp_addr_lo;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata = '0;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msrv32_dmem_ahb_master #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst_n),
    .req_valid_in        (req_valid),
    .req_ready_out       (req_ready),
    .req_addr_in         (req_addr),
    .req_write_in        (req_write),
    .req_size_in         (req_size),
    .req_wdata_in        (req_wdata),
    .rsp_valid_out       (rsp_valid),
    .rsp_rdata_out       (rsp_rdata),
    .rsp_err_out         (rsp_err),
    .rsp_misaligned_out  (rsp_mis),
    .rsp_addr_1_to_0_out (rsp_addr_lo),
    .haddr_out           (haddr),
    .htrans_out          (htrans),
    .hwrite_out          (hwrite),
    .hsize_out           (hsize),
    .hwdata_out          (hwdata),
    .hrdata_in           (hrdata),
    .hready_in           (hready),
    .hresp_in            (hresp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                         input logic [31:0] wdata);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_size  = size;
    req_wdata = wdata;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_htrans", htrans, 32'h0);
    check("rst_rsp_valid", rsp_valid, 32'h0);
    check("rst_haddr", haddr, 32'h0);
    check("rst_hwdata", hwdata, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_ready", req_ready, 32'h1);

    // Word load, zero wait
    request(32'h0000_1000, 1'b0, 2'b10, 32'h0);
    tick();  // cycle 1
    req_valid = 1'b0;
    check("ld_htrans_c1", htrans, 32'h2);
    check("ld_haddr_c1", haddr, 32'h0000_1000);
    check("ld_hsize_c1", hsize, 32'h2);
    check("ld_hwrite_c1", hwrite, 32'h0);
    check("ld_ready_c1", req_ready, 32'h0);
    tick();  // cycle 2
    check("ld_htrans_c2", htrans, 32'h0);
    check("ld_valid_c2", rsp_valid, 32'h0);
    hrdata = 32'h1234_5678;
    tick();  // cycle 3
    hrdata = 32'hDEAD_BEEF;
    check("ld_valid_c3", rsp_valid, 32'h1);
    check("ld_rdata", rsp_rdata, 32'h1234_5678);
    check("ld_err", rsp_err, 32'h0);
    check("ld_addr_lo", rsp_addr_lo, 32'h0);
    check("ld_ready_c3", req_ready, 32'h1);
    tick();
    check("ld_pulse", rsp_valid, 32'h0);

    // Byte store, 2 data-phase wait states
    request(32'h0000_1003, 1'b1, 2'b00, 32'h7800_0000);
    tick();  // cycle 1
    req_valid = 1'b0;
    check("st_hsize", hsize, 32'h0);
    check("st_hwrite", hwrite, 32'h1);
    check("st_htrans", htrans, 32'h2);
    check("st_haddr", haddr, 32'h0000_1003);
    tick();  // cycle 2
    check("st_hwdata_c2", hwdata, 32'h7800_0000);
    hready = 1'b0;
    tick();  // cycle 3
    check("st_hwdata_c3", hwdata, 32'h7800_0000);
    check("st_valid_c3", rsp_valid, 32'h0);
    tick();  // cycle 4
    check("st_hwdata_c4", hwdata, 32'h7800_0000);
    check("st_valid_c4", rsp_valid, 32'h0);
    hready = 1'b1;
    tick();  // cycle 5
    check("st_valid_c5", rsp_valid, 32'h1);
    check("st_err", rsp_err, 32'h0);
    check("st_rdata_kept", rsp_rdata, 32'h1234_5678);
    check("st_addr_lo", rsp_addr_lo, 32'h3);
    tick();

    // Misaligned half load
    request(32'h0000_2001, 1'b0, 2'b01, 32'h0);
    tick();  // cycle 1
    req_valid = 1'b0;
    check("mis_htrans", htrans, 32'h0);
    check("mis_valid", rsp_valid, 32'h1);
    check("mis_err", rsp_err, 32'h1);
    check("mis_flag", rsp_mis, 32'h1);
    check("mis_addr_lo", rsp_addr_lo, 32'h1);
    tick();  // cycle 2
    check("mis_valid_c2", rsp_valid, 32'h0);
    check("mis_err_c2", rsp_err, 32'h0);
    check("mis_ready_c2", req_ready, 32'h1);

    // Illegal size
    request(32'h0000_2000, 1'b0, 2'b11, 32'h0);
    tick();
    req_valid = 1'b0;
    check("ill_htrans", htrans, 32'h0);
    check("ill_valid", rsp_valid, 32'h1);
    check("ill_err", rsp_err, 32'h1);
    check("ill_flag", rsp_mis, 32'h1);
    tick();

    // Slave ERROR, then back-to-back accept on the response cycle
    request(32'h0000_3000, 1'b0, 2'b10, 32'h0);
    tick();  // cycle 1
    req_valid = 1'b0;
    tick();  // cycle 2
    hready = 1'b0;
    hresp  = 1'b1;
    tick();  // cycle 3
    check("err_valid_c3", rsp_valid, 32'h0);
    hready = 1'b1;
    tick();  // cycle 4
    hresp = 1'b0;
    check("err_valid", rsp_valid, 32'h1);
    check("err_err", rsp_err, 32'h1);
    check("err_mis", rsp_mis, 32'h0);
    check("err_ready", req_ready, 32'h1);
    request(32'h0000_3004, 1'b0, 2'b10, 32'h0);
    tick();  // cycle 5
    req_valid = 1'b0;
    check("b2b_htrans", htrans, 32'h2);
    check("b2b_haddr", haddr, 32'h0000_3004);
    tick();
    hrdata = 32'hCAFE_F00D;
    tick();
    check("b2b_valid", rsp_valid, 32'h1);
    check("b2b_rdata", rsp_rdata, 32'hCAFE_F00D);
    check("b2b_err", rsp_err, 32'h0);

    // Timeout: HREADY low 10 cycles in the address phase
    request(32'h0000_4000, 1'b0, 2'b10, 32'h0);
    tick();  // cycle 1
    req_valid = 1'b0;
    hready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      check($sformatf("to_valid_c%0d", i), rsp_valid, {31'b0, (i == 5)});
      check($sformatf("to_err_c%0d", i), rsp_err, {31'b0, (i == 5)});
      check($sformatf("to_ready_c%0d", i), req_ready, 32'h0);
      check($sformatf("to_htrans_c%0d", i), htrans, 32'h2);
      if (i < 10) tick();
    end
    tick();  // cycle 11
    hready = 1'b1;
    check("to_ready_c11", req_ready, 32'h0);
    tick();  // cycle 12
    check("to_ready_c12", req_ready, 32'h1);
    check("to_htrans_c12", htrans, 32'h0);
    check("to_no_rsp", rsp_valid, 32'h0);

    // Reset in the address phase with HREADY low
    request(32'h0000_5000, 1'b0, 2'b10, 32'h0);
    tick();  // cycle 1
    req_valid = 1'b0;
    hready = 1'b0;
    check("rr_htrans_pre", htrans, 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_htrans_async", htrans, 32'h0);
    tick();
    tick();
    check("rr_no_rsp", rsp_valid, 32'h0);
    rst_n = 1'b1;
    hready = 1'b1;
    tick();
    check("rr_ready", req_ready, 32'h1);
    check("rr_no_rsp2", rsp_valid, 32'h0);
    request(32'h0000_6000, 1'b0, 2'b10, 32'h0);
    tick();
    req_valid = 1'b0;
    check("rr_htrans", htrans, 32'h2);
    tick();
    hrdata = 32'hA5A5_5A5A;
    tick();
    check("rr_valid", rsp_valid, 32'h1);
    check("rr_rdata", rsp_rdata, 32'hA5A5_5A5A);
    check("rr_err", rsp_err, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msrv32_dmem_ahb_master.md
Name: msrv32_dmem_ahb_master

Overview:
Data-side AHB-Lite master for the msrv32 core; sits directly upstream of msrv32_load_unit.
- Accepts one load/store request at a time from the execute/store path.
- Runs the AHB address and data phases, including wait states and the two-cycle ERROR response.
- Returns registered read data, the error flag and address[1:0], which feed the load unit's ms_riscv32_mp_dmdata_in, ahb_resp_in and iadder_out_1_to_0_in.

Parameters:
TIMEOUT_CYCLES, 255, count of consecutive HREADY-low cycles before the core is given an error; 0 disables the timeout.

Ports:
ms_riscv32_mp_clk_in  input  1  core clock
ms_riscv32_mp_rst_in  input  1  reset, asynchronous, active-low
req_valid_in  input  1  core request valid
req_ready_out  output  1  block can accept a request; high only in IDLE
req_addr_in  input  32  byte address
req_write_in  input  1  1 = store, 0 = load
req_size_in  input  2  00 byte, 01 half, 10 word, 11 illegal
req_wdata_in  input  32  store data, already lane-aligned by the store unit
rsp_valid_out  output  1  one-cycle response pulse
rsp_rdata_out  output  32  captured HRDATA, to the load unit
rsp_err_out  output  1  bus error, timeout or misaligned; to ahb_resp_in
rsp_misaligned_out  output  1  error was caused by misalignment or illegal size
rsp_addr_1_to_0_out  output  2  latched req_addr_in[1:0], to the load unit
haddr_out  output  32  AHB HADDR
htrans_out  output  2  AHB HTRANS (00 IDLE, 10 NONSEQ only)
hwrite_out  output  1  AHB HWRITE
hsize_out  output  3  AHB HSIZE, {1'b0, req_size}
hwdata_out  output  32  AHB HWDATA
hrdata_in  input  32  AHB HRDATA
hready_in  input  1  AHB HREADY
hresp_in  input  1  AHB HRESP (0 OKAY, 1 ERROR)

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE; wait counter cleared.
  - All registered outputs go to 0; htrans_out = IDLE.
  - req_ready_out = 1 once reset releases.
  - Reset mid-transfer abandons the transfer immediately: HTRANS returns to IDLE asynchronously and no response is issued.
- All AHB outputs and rsp_* outputs are registered. req_ready_out is decoded from state.
- Handshake: a request is accepted when req_valid_in && req_ready_out. Address, write, size, wdata and addr[1:0] are latched on acceptance. Only one transfer is ever outstanding.
- Misalignment check at accept:
  - Misaligned: half with addr[0] = 1; word with addr[1:0] != 0; size 11.
  - No bus transfer is issued.
  - State goes to RESP. The next cycle carries rsp_valid = 1, rsp_err = 1, rsp_misaligned = 1.
- FSM states: IDLE, ADDR, DATA, ERR, DRAIN, RESP.
  - IDLE → ADDR on an aligned accept. haddr/hwrite/hsize are driven and htrans = NONSEQ.
  - ADDR: hold all address-phase signals while hready_in = 0. When hready_in = 1: htrans → IDLE, go to DATA; hwdata_out = latched wdata, held through the whole of DATA.
  - DATA, hready_in = 1 and hresp_in = 0: capture hrdata_in into rsp_rdata_out (loads only; stores leave it unchanged). Next cycle: rsp_valid = 1, rsp_err = 0. State → IDLE.
  - DATA, hready_in = 0 and hresp_in = 1: first ERROR cycle, go to ERR. In ERR, when hready_in = 1: rsp_valid = 1, rsp_err = 1 next cycle, state → IDLE.
  - DATA, hready_in = 1 and hresp_in = 1 (protocol violation): treated as an error response.
- Minimum latency: a zero-wait load accepted in cycle 0 gives rsp_valid in cycle 3. Each wait state adds 1 cycle.
- Timeout:
  - The counter increments on every cycle in ADDR or DATA with hready_in = 0 and clears on hready_in = 1.
  - When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): rsp_valid = 1 and rsp_err = 1 next cycle; htrans is held at its current value (NONSEQ if still in ADDR, IDLE if in DATA); state → DRAIN.
  - DRAIN waits for hready_in = 1, discards the data and returns to IDLE. No response is issued from DRAIN.
  - The counter saturates and never wraps.
- Response outputs:
  - rsp_valid_out is a single-cycle pulse.
  - rsp_err_out and rsp_misaligned_out are valid only with rsp_valid_out and are 0 otherwise.
  - rsp_rdata_out and rsp_addr_1_to_0_out hold their values until the next response.
- A new request may be accepted in the same cycle rsp_valid_out is high, because the state is already IDLE.

Decomposition:
- Shared defines package (msrv32_pkg): HTRANS codes, HSIZE codes, FSM state encodings, load/store size codes (shared with the load and store units).
- One natural sub-module: msrv32_wait_timer. It is the saturating HREADY-low counter with a timeout compare, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Word load, addr 0x0000_1000, zero wait, HRDATA 0x1234_5678 → htrans NONSEQ in cycle 1, rsp_valid in cycle 3, rdata 0x1234_5678, err 0, addr_1_to_0 00.
- Byte store to 0x0000_1003, wdata 0x7800_0000, 2 wait states in the data phase → hsize 000, hwrite 1, hwdata 0x7800_0000 held for 3 cycles, rsp_valid in cycle 5, rdata unchanged.
- Half load at 0x0000_2001 → no NONSEQ on the bus, rsp_valid in cycle 1 with err = 1 and misaligned = 1; size 11 gives the same result.
- Word load with slave ERROR (HREADY 0/HRESP 1, then HREADY 1/HRESP 1) → rsp_valid with err = 1, misaligned = 0, returns to IDLE; the next request is accepted.
- TIMEOUT_CYCLES = 4, HREADY held low for 10 cycles → err response after the 4th low cycle, req_ready stays 0 until HREADY rises, then returns to 1.
- Reset asserted while in ADDR with HREADY low → htrans_out = 00 immediately, no rsp_valid; after release req_ready = 1 and a new load completes normally.
